// File: rtl/clkgen_pkg.sv
// Shared definitions for the programmable clock generator: widths, limits and
// the parameter legality check used at elaboration.
package clkgen_pkg;

    localparam int NCYC_W = 32;
    localparam logic [NCYC_W-1:0] NCYC_MAX = {NCYC_W{1'b1}};

    function automatic int clkgen_cnt_w(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

    function automatic bit clkgen_params_ok(input int div, input int high_cyc,
                                            input int phase_cyc, input int cnt_w);
        return (div >= 2) && (high_cyc >= 1) && (high_cyc <= div - 1) &&
               (phase_cyc >= 0) && (phase_cyc <= div - 1) &&
               (cnt_w == clkgen_cnt_w(div));
    endfunction

endpackage

// File: rtl/clkgen_sync2.sv
// Two-flop synchroniser; anything other than a clean 1 on the input samples as 0.
module clkgen_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = (d === 1'b1);
        s2_d = s1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/tb_clk_gen.sv
// Programmable clock generator: divides clk_ref by DIV with gated, whole-period
// starts and stops controlled by the hierarchically written variable en.
module tb_clk_gen
    import clkgen_pkg::*;
#(
    parameter int DIV       = 4,
    parameter int HIGH_CYC  = 2,
    parameter int PHASE_CYC = 0,
    parameter int CNT_W     = clkgen_cnt_w(DIV)
) (
    input  logic              clk_ref,
    input  logic              rst_n,
    output logic              clk,
    output logic              running,
    output logic [NCYC_W-1:0] ncyc
);

    if (!clkgen_params_ok(DIV, HIGH_CYC, PHASE_CYC, CNT_W)) begin : g_param_err
        $error("tb_clk_gen: illegal parameters DIV=%0d HIGH_CYC=%0d PHASE_CYC=%0d CNT_W=%0d",
               DIV, HIGH_CYC, PHASE_CYC, CNT_W);
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HIGH = CNT_W'(HIGH_CYC);
    localparam logic [CNT_W-1:0] CNT_RST  = CNT_W'((DIV - PHASE_CYC) % DIV);

    logic en = 1'b0;
    logic en_s2;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              running_q, running_d;
    logic              clk_q, clk_d;
    logic [NCYC_W-1:0] ncyc_q, ncyc_d;

    clkgen_sync2 u_en_sync (
        .clk   (clk_ref),
        .rst_n (rst_n),
        .d     (en),
        .q     (en_s2)
    );

    // Gate may only change at the period boundary, where clk is already low.
    always_comb begin
        cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        running_d = (cnt_q == CNT_LAST) ? en_s2 : running_q;
        clk_d     = running_d && (cnt_d < CNT_HIGH);
        ncyc_d    = ncyc_q;
        if (clk_d && !clk_q && (ncyc_q != NCYC_MAX)) begin
            ncyc_d = ncyc_q + 1'b1;
        end
    end

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= CNT_RST;
            running_q <= 1'b0;
            clk_q     <= 1'b0;
            ncyc_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            running_q <= running_d;
            clk_q     <= clk_d;
            ncyc_q    <= ncyc_d;
        end
    end

    assign clk     = clk_q;
    assign running = running_q;
    assign ncyc    = ncyc_q;

endmodule

// File: tb/tb_tb_clk_gen.sv
// Directed bench for tb_clk_gen: DIV=4 main instance plus two DIV=3 instances
// that differ only in PHASE_CYC.
module tb_tb_clk_gen;

    localparam int PERIOD = 10;

    logic        clk_ref = 1'b0;
    logic        rst_n   = 1'b0;
    logic        clk, running;
    logic [31:0] ncyc;
    logic        clk3a, running3a;
    logic [31:0] ncyc3a;
    logic        clk3b, running3b;
    logic [31:0] ncyc3b;

    int tests_run    = 0;
    int tests_failed = 0;
    int edge_n       = 0;

    longint last_rise = 0;
    longint prev_rise = 0;
    longint last_fall = 0;

    always #(PERIOD / 2) clk_ref = ~clk_ref;

    tb_clk_gen #(.DIV(4), .HIGH_CYC(2), .PHASE_CYC(0)) dut (
        .clk_ref (clk_ref),
        .rst_n   (rst_n),
        .clk     (clk),
        .running (running),
        .ncyc    (ncyc)
    );

    tb_clk_gen #(.DIV(3), .HIGH_CYC(1), .PHASE_CYC(0)) u_d3p0 (
        .clk_ref (clk_ref),
        .rst_n   (rst_n),
        .clk     (clk3a),
        .running (running3a),
        .ncyc    (ncyc3a)
    );

    tb_clk_gen #(.DIV(3), .HIGH_CYC(1), .PHASE_CYC(1)) u_d3p1 (
        .clk_ref (clk_ref),
        .rst_n   (rst_n),
        .clk     (clk3b),
        .running (running3b),
        .ncyc    (ncyc3b)
    );

    always @(posedge clk) begin
        prev_rise = last_rise;
        last_rise = $time;
    end

    always @(negedge clk) last_fall = $time;

    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_ref);
            edge_n++;
            @(negedge clk_ref);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk_ref);
        checkOutput("reset_clk", 32'(clk), 32'd0);
        checkOutput("reset_running", 32'(running), 32'd0);
        checkOutput("reset_ncyc", ncyc, 32'd0);
        rst_n  = 1'b1;
        edge_n = 0;

        // Idle with en low: nothing may move.
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1);
            checkOutput("idle_clk", 32'(clk), 32'd0);
            checkOutput("idle_running", 32'(running), 32'd0);
            checkOutput("idle_ncyc", ncyc, 32'd0);
        end

        // Enable after edge 20: en_s2 high after edge 22, boundary at edge 24.
        dut.en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1);
            checkOutput("start_wait_clk", 32'(clk), 32'd0);
        end
        applyStimulus(1);
        checkOutput("first_rise_clk", 32'(clk), 32'd1);
        checkOutput("first_rise_running", 32'(running), 32'd1);
        checkOutput("first_rise_ncyc", ncyc, 32'd1);
        while (edge_n < 60) begin
            applyStimulus(1);
            checkOutput("run_clk", 32'(clk), 32'((edge_n % 4) < 2));
            checkOutput("run_ncyc", ncyc, 32'((edge_n - 24) / 4 + 1));
        end
        checkOutput("ten_rises_ncyc", ncyc, 32'd10);
        checkOutput("period", 32'(last_rise - prev_rise), 32'(4 * PERIOD));

        // Disable one edge after the rise at edge 60: high phase still completes.
        applyStimulus(1);
        dut.en = 1'b0;
        applyStimulus(1);
        checkOutput("stop_fall_clk", 32'(clk), 32'd0);
        checkOutput("high_time", 32'(last_fall - last_rise), 32'(2 * PERIOD));
        while (edge_n < 72) begin
            applyStimulus(1);
            checkOutput("stopped_clk", 32'(clk), 32'd0);
            checkOutput("stopped_ncyc", ncyc, 32'd10);
        end
        checkOutput("stopped_running", 32'(running), 32'd0);

        // Restart, then reset asynchronously while clk is high.
        dut.en = 1'b1;
        applyStimulus(4);
        checkOutput("restart_clk", 32'(clk), 32'd1);
        checkOutput("restart_ncyc", ncyc, 32'd11);
        applyStimulus(1);
        checkOutput("restart_high_clk", 32'(clk), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_clk", 32'(clk), 32'd0);
        checkOutput("async_rst_running", 32'(running), 32'd0);
        checkOutput("async_rst_ncyc", ncyc, 32'd0);
        @(negedge clk_ref);
        rst_n  = 1'b1;
        edge_n = 0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1);
            checkOutput("post_rst_wait_clk", 32'(clk), 32'd0);
        end
        applyStimulus(1);
        checkOutput("post_rst_rise_clk", 32'(clk), 32'd1);
        checkOutput("post_rst_rise_ncyc", ncyc, 32'd1);

        // DIV=3 pair: PHASE_CYC=1 rises one edge after PHASE_CYC=0.
        u_d3p0.en = 1'b1;
        u_d3p1.en = 1'b1;
        rst_n = 1'b0;
        #1;
        @(negedge clk_ref);
        rst_n  = 1'b1;
        edge_n = 0;
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1);
            checkOutput("d3_phase0_clk", 32'(clk3a), 32'((k >= 3) && (k % 3 == 0)));
            checkOutput("d3_phase1_clk", 32'(clk3b), 32'((k >= 4) && (k % 3 == 1)));
        end
        checkOutput("d3_phase0_ncyc", ncyc3a, 32'd3);
        checkOutput("d3_phase1_ncyc", ncyc3b, 32'd3);

        // Saturation: main instance rises at edges 12, 16, 20, 24 from here.
        force dut.ncyc_q = 32'hFFFF_FFFD;
        #1;
        release dut.ncyc_q;
        checkOutput("sat_preload", ncyc, 32'hFFFF_FFFD);
        applyStimulus(2);
        checkOutput("sat_step1", ncyc, 32'hFFFF_FFFE);
        applyStimulus(4);
        checkOutput("sat_step2", ncyc, 32'hFFFF_FFFF);
        applyStimulus(8);
        checkOutput("sat_hold_clk", 32'(clk), 32'd1);
        checkOutput("sat_hold_ncyc", ncyc, 32'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
